uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit-side controller that drains the UART TX async FIFO's read port and serializes each byte onto `txd` as an asynchronous serial frame. It runs entirely in the FIFO read-clock domain. It pops exactly one word per frame, and that word is valid at the read port while `rempty` is low. It applies runtime frame configuration: baud divisor, parity, and stop bits.

## Interface
Parameters:
- `DSIZE`, 8, data bits per frame; must match the FIFO data width.
- `DIVW`, 16, width of the baud divisor.

Ports:
- `rclk` input 1: FIFO read clock; the only clock.
- `rrst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: permits starting new frames.
- `baud_div` input DIVW: clocks per bit minus 1.
- `par_en` input 1: parity bit present.
- `par_odd` input 1: odd parity when set, even when clear.
- `stop2` input 1: two stop bits when set, one when clear.
- `rempty` input 1: FIFO empty flag.
- `rdata` input DSIZE: FIFO head word.
- `rinc` output 1: FIFO pop strobe, one cycle per frame.
- `txd` output 1: serial line; idle high.
- `busy` output 1: frame in progress.
- `frame_done` output 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state = IDLE, `txd` = 1, `busy` = 0, `rinc` = 0, `frame_done` = 0, all counters = 0.
- **Launch condition (`go`)**: `go` = `enable` && !`rempty`, evaluated in IDLE or in the last cycle of the final stop bit.
  - When `go` is true: `rinc` = 1 for that cycle; `rdata` is loaded into the shift register; `baud_div`, `par_en`, `par_odd` and `stop2` are latched.
  - Next state is START.
- **Config latching**: config inputs are used only as latched at frame start. Changes mid-frame have no effect until the next frame.
- **Bit period**: D = `baud_div` + 1 cycles. `baud_div` = 0 gives one cycle per bit.
- **Frame order**:
  - START: `txd` = 0.
  - DATA: DSIZE bits, LSB first; bit index counts 0..DSIZE-1.
  - PARITY (only if `par_en`): XOR-reduce of the data, XOR `par_odd`.
  - STOP: `txd` = 1 for 1 or 2 bit periods.
- **Back-to-back frames**: if `go` is true in the last STOP cycle, the next START follows with no idle cycle. Otherwise return to IDLE.
- **Disable**: `enable` deasserted mid-frame lets the current frame complete; no further pops.
- **Empty FIFO**: `rempty` = 1 means no pop and `txd` stays 1. `rinc` is never asserted while `rempty` = 1.
- **Reset mid-frame**: `txd` forced to 1 immediately (asynchronous). The popped word is discarded.
- `busy` = 1 in every state except IDLE.

## Timing
- **Cycle T**: `go` is true, so `rinc` = 1 (combinational from registered state and `rempty`).
- **Edge ending T**: data captured; state becomes START.
- **Registered outputs**: `txd` and `busy` are registered. `txd` = 0 from T+1 through T+D.
- **Frame length**: D × (1 + DSIZE + `par_en` + 1 + `stop2`) cycles, measured from T+1.
- **Pop spacing**: consecutive `rinc` pulses are exactly one frame length apart when the FIFO stays non-empty.
- **Empty flag**: the FIFO's registered `rempty` updates within one cycle after the pop. This is always before the next pop opportunity, since the minimum frame is 10 cycles.
- **Divisor counter**: loads D−1 at each bit start and decrements to 0. A bit ends when the counter is 0. There is no wrap ambiguity.

## Structure
- **Shared package `uart_pkg`**:
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - Constants for the idle line level (1) and the start level (0).
  - The default `DIVW`.
- **Sub-module `uart_baud_cnt`**:
  - Inputs: `load` and `div`.
  - Outputs: a `bit_end` pulse.
  - Also reused by the future RX block.

## Test plan
- **8N1 single byte**: `baud_div` = 3, 8N1, FIFO holds 0xA5.
  - `rinc` pulses once.
  - `txd` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 total).
  - `frame_done` pulses in cycle 40; `busy` falls after it.
- **Parity**: 0xA5, `par_en` = 1.
  - Even parity: parity bit = 0.
  - `par_odd` = 1: parity bit = 1.
  - Frame = 44 cycles at `baud_div` = 3.
- **Back-to-back**: 0x00 then 0xFF, `stop2` = 1, `baud_div` = 0.
  - `rinc` pulses 11 cycles apart.
  - Second start bit immediately follows the second stop bit; no idle cycle.
- **Empty / disable**:
  - `rempty` = 1 for 100 cycles: `txd` = 1 and `rinc` = 0 throughout.
  - `enable` dropped mid-frame: frame completes and no second pop occurs.
- **Config change mid-frame**: `baud_div` changed from 3 to 7 mid-frame.
  - Current bits stay 4 cycles.
  - Next frame uses 8-cycle bits.
- **Reset mid-frame**: `rrst_n` asserted during DATA.
  - `txd` = 1 and `busy` = 0 asynchronously.
  - After release with the FIFO non-empty, a new frame starts cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line levels and default widths.
// Imported by the TX scheduler and the baud counter (also intended for the RX side).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam int   DEF_DIVW   = 16;

endpackage

// File: rtl/uart_tx_sched_if.sv
// FIFO read-port bundle between the TX async FIFO and the transmit scheduler.
// master = the consumer that pops words, slave = the FIFO read side.
interface uart_tx_sched_if #(
  parameter int DSIZE = 8
);

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;

  modport master (input rempty, input rdata, output rinc);
  modport slave  (output rempty, output rdata, input rinc);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: load div (= clocks per bit - 1), bit_end while at zero.
// Loading in the bit_end cycle gives back-to-back bits with no gap.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIVW = DEF_DIVW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            bit_end
);

  logic [DIVW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops one FIFO word per frame and serializes it on txd
// with per-frame latched divisor, parity and stop-bit configuration.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int DIVW  = DEF_DIVW
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            enable,
  input  logic [DIVW-1:0] baud_div,
  input  logic            par_en,
  input  logic            par_odd,
  input  logic            stop2,
  uart_tx_sched_if.master fifo,
  output logic            txd,
  output logic            busy,
  output logic            frame_done
);

  localparam int IW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DSIZE - 1);

  tx_state_e        state_q, state_d;
  logic [DSIZE-1:0] shift_q, shift_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic             par_q, par_d;
  logic [DIVW-1:0]  div_q, div_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;

  logic            bit_end;
  logic            cnt_load;
  logic [DIVW-1:0] cnt_div;
  logic            last_stop;
  logic            go;
  logic            rinc_c;
  logic            frame_done_c;

  uart_baud_cnt #(.DIVW(DIVW)) u_baud (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .load    (cnt_load),
    .div     (cnt_div),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    par_d        = par_q;
    div_d        = div_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    txd_d        = txd_q;
    busy_d       = busy_q;
    cnt_load     = 1'b0;
    cnt_div      = div_q;
    rinc_c       = 1'b0;
    frame_done_c = 1'b0;

    last_stop = (state_q == STOP) && bit_end && (!stop2_q || stop_idx_q);
    // Reset gating keeps rinc low while rrst_n is held, even with data waiting.
    go = enable && !fifo.rempty && rrst_n && ((state_q == IDLE) || last_stop);

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          cnt_load  = 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_load = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = STOP;
              txd_d      = LINE_IDLE;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          txd_d      = LINE_IDLE;
          stop_idx_d = 1'b0;
          cnt_load   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_load   = 1'b1;
          end else begin
            frame_done_c = 1'b1;
            state_d      = IDLE;
            txd_d        = LINE_IDLE;
            busy_d       = 1'b0;
          end
        end
      end
      default: begin
        txd_d  = LINE_IDLE;
        busy_d = 1'b0;
      end
    endcase

    // A launch overrides the return to IDLE so the next start bit follows directly.
    if (go) begin
      rinc_c     = 1'b1;
      shift_d    = fifo.rdata;
      par_d      = (^fifo.rdata) ^ par_odd;
      div_d      = baud_div;
      par_en_d   = par_en;
      stop2_d    = stop2;
      cnt_load   = 1'b1;
      cnt_div    = baud_div;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
      state_d    = START;
      txd_d      = LINE_START;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= LINE_IDLE;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo.rinc  = rinc_c;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_c;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO model, per-cycle line capture and
// a frame-level reference built from start/data/parity/stop rules.
module tb_uart_tx_sched;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        enable;
  logic [15:0] baud_div;
  logic        par_en;
  logic        par_odd;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic        frame_done;

  uart_tx_sched_if #(.DSIZE(8)) fif ();

  uart_tx_sched #(.DSIZE(8), .DIVW(16)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .baud_div   (baud_div),
    .par_en     (par_en),
    .par_odd    (par_odd),
    .stop2      (stop2),
    .fifo       (fif.master),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 rclk = ~rclk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] fq[$];
  bit         pop_pend;
  bit         cap_txd[$];
  bit         cap_rinc[$];
  bit         cap_fd[$];
  bit         cap_busy[$];
  bit         exp_q[$];

  task automatic sync(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic clr();
    cap_txd.delete();
    cap_rinc.delete();
    cap_fd.delete();
    cap_busy.delete();
    exp_q.delete();
  endtask

  task automatic cfg(input int d, input bit pe, input bit po, input bit s2);
    baud_div = 16'(d);
    par_en   = pe;
    par_odd  = po;
    stop2    = s2;
  endtask

  // Reference frame: start, LSB-first data, optional parity, 1 or 2 stops, each d cycles.
  task automatic add_frame(input logic [7:0] b, input int d, input bit pe,
                           input bit po, input bit s2);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back((^b) ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (d) exp_q.push_back(bits[i]);
  endtask

  function automatic int mism(input int start);
    int m = 0;
    if (start < 0 || start + exp_q.size() > cap_txd.size()) return -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (cap_txd[start+i] != exp_q[i]) m++;
    return m;
  endfunction

  function automatic int find_rinc(input int from);
    for (int i = from; i < cap_rinc.size(); i++)
      if (cap_rinc[i]) return i;
    return -1;
  endfunction

  function automatic int count_q(input bit q[$]);
    int c = 0;
    foreach (q[i]) if (q[i]) c++;
    return c;
  endfunction

  task automatic test_reset();
    enable = 1'b1;
    cfg(3, 0, 0, 0);
    fq.push_back(8'h3C);
    rrst_n = 1'b0;
    sync(3);
    n_chk++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b exp=1", txd); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (fif.rinc !== 1'b0) begin n_fail++; $display("FAIL reset_rinc got=%b exp=0", fif.rinc); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    enable = 1'b0;
    fq.delete();
    sync(2);
    rrst_n = 1'b1;
    sync(2);
    $display("reset: txd=%b busy=%b rinc=%b", txd, busy, fif.rinc);
  endtask

  task automatic test_8n1();
    int t;
    clr();
    cfg(3, 0, 0, 0);
    enable = 1'b1;
    fq.push_back(8'hA5);
    add_frame(8'hA5, 4, 0, 0, 0);
    sync(60);
    t = find_rinc(0);
    n_chk++; if (t < 0) begin n_fail++; $display("FAIL 8n1_pop got=none exp=one"); end
    n_chk++; if (count_q(cap_rinc) != 1) begin n_fail++; $display("FAIL 8n1_rinc_count got=%0d exp=1", count_q(cap_rinc)); end
    n_chk++; if (mism(t+1) != 0) begin n_fail++; $display("FAIL 8n1_line got=%0d bad cycles exp=0", mism(t+1)); end
    n_chk++; if (cap_fd[t+40] !== 1'b1 || count_q(cap_fd) != 1) begin n_fail++; $display("FAIL 8n1_frame_done got=%b/%0d exp=1/1", cap_fd[t+40], count_q(cap_fd)); end
    n_chk++; if (cap_busy[t+40] !== 1'b1 || cap_busy[t+41] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy got=%b%b exp=10", cap_busy[t+40], cap_busy[t+41]); end
    $display("frame 8n1 data=a5 div=3 pop_at=%0d", t);
  endtask

  task automatic test_parity();
    int t;
    for (int po = 0; po < 2; po++) begin
      clr();
      cfg(3, 1, po[0], 0);
      fq.push_back(8'hA5);
      add_frame(8'hA5, 4, 1, po[0], 0);
      sync(60);
      t = find_rinc(0);
      n_chk++; if (mism(t+1) != 0) begin n_fail++; $display("FAIL parity_line odd=%0d got=%0d bad cycles exp=0", po, mism(t+1)); end
      n_chk++; if (cap_txd[t+37] !== po[0]) begin n_fail++; $display("FAIL parity_bit odd=%0d got=%b exp=%b", po, cap_txd[t+37], po[0]); end
      n_chk++; if (cap_fd[t+44] !== 1'b1) begin n_fail++; $display("FAIL parity_len odd=%0d got=%b exp=1 at 44", po, cap_fd[t+44]); end
      $display("frame parity data=a5 odd=%0d pop_at=%0d", po, t);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    clr();
    cfg(0, 0, 0, 1);
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    add_frame(8'h00, 1, 0, 0, 1);
    add_frame(8'hFF, 1, 0, 0, 1);
    sync(40);
    t1 = find_rinc(0);
    t2 = find_rinc(t1 + 1);
    n_chk++; if (t1 < 0 || t2 - t1 != 11) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=11", t2 - t1); end
    n_chk++; if (mism(t1+1) != 0) begin n_fail++; $display("FAIL b2b_line got=%0d bad cycles exp=0", mism(t1+1)); end
    n_chk++; if (cap_txd[t1+12] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start got=%b exp=0", cap_txd[t1+12]); end
    $display("frames b2b 00,ff pops_at=%0d,%0d", t1, t2);
  endtask

  task automatic test_empty();
    clr();
    cfg(0, 0, 0, 0);
    sync(100);
    n_chk++; if (count_q(cap_rinc) != 0) begin n_fail++; $display("FAIL empty_rinc got=%0d exp=0", count_q(cap_rinc)); end
    n_chk++; if (count_q(cap_txd) != cap_txd.size()) begin n_fail++; $display("FAIL empty_txd got=%0d high exp=%0d", count_q(cap_txd), cap_txd.size()); end
    $display("empty: %0d cycles idle", cap_txd.size());
  endtask

  task automatic test_disable();
    int t;
    clr();
    cfg(1, 0, 0, 0);
    fq.push_back(8'h3C);
    fq.push_back(8'hC3);
    add_frame(8'h3C, 2, 0, 0, 0);
    sync(6);
    enable = 1'b0;
    sync(60);
    t = find_rinc(0);
    n_chk++; if (count_q(cap_rinc) != 1) begin n_fail++; $display("FAIL disable_pops got=%0d exp=1", count_q(cap_rinc)); end
    n_chk++; if (mism(t+1) != 0) begin n_fail++; $display("FAIL disable_line got=%0d bad cycles exp=0", mism(t+1)); end
    n_chk++; if (cap_busy[cap_busy.size()-1] !== 1'b0) begin n_fail++; $display("FAIL disable_busy got=%b exp=0", cap_busy[cap_busy.size()-1]); end
    $display("frame disable data=3c pop_at=%0d left_in_fifo=%0d", t, fq.size());
    fq.delete();
    sync(2);
    enable = 1'b1;
  endtask

  task automatic test_cfg_change();
    int t1, t2;
    clr();
    cfg(3, 0, 0, 0);
    fq.push_back(8'h5A);
    fq.push_back(8'h96);
    add_frame(8'h5A, 4, 0, 0, 0);
    add_frame(8'h96, 8, 0, 0, 0);
    sync(10);
    baud_div = 16'd7;
    sync(140);
    t1 = find_rinc(0);
    t2 = find_rinc(t1 + 1);
    n_chk++; if (t1 < 0 || t2 - t1 != 40) begin n_fail++; $display("FAIL cfg_spacing got=%0d exp=40", t2 - t1); end
    n_chk++; if (mism(t1+1) != 0) begin n_fail++; $display("FAIL cfg_line got=%0d bad cycles exp=0", mism(t1+1)); end
    $display("frames cfg_change 5a(div3),96(div7) pops_at=%0d,%0d", t1, t2);
  endtask

  task automatic test_reset_mid();
    int t;
    cfg(3, 0, 0, 0);
    fq.push_back(8'h81);
    sync(12);
    n_chk++; if (txd !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b%b exp=01", txd, busy); end
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    #1;
    n_chk++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got=%b%b exp=10", txd, busy); end
    fq.push_back(8'h7E);
    sync(3);
    clr();
    add_frame(8'h7E, 4, 0, 0, 0);
    rrst_n = 1'b1;
    sync(60);
    t = find_rinc(0);
    n_chk++; if (count_q(cap_rinc) != 1) begin n_fail++; $display("FAIL rstmid_pops got=%0d exp=1", count_q(cap_rinc)); end
    n_chk++; if (mism(t+1) != 0) begin n_fail++; $display("FAIL rstmid_line got=%0d bad cycles exp=0", mism(t+1)); end
    $display("frame after reset data=7e pop_at=%0d", t);
  endtask

  task automatic test_random();
    int t, d, len;
    logic [7:0] b;
    bit pe, po, s2;
    for (int k = 0; k < 8; k++) begin
      clr();
      b  = 8'($urandom_range(255, 0));
      d  = $urandom_range(5, 1);
      pe = 1'($urandom_range(1, 0));
      po = 1'($urandom_range(1, 0));
      s2 = 1'($urandom_range(1, 0));
      cfg(d - 1, pe, po, s2);
      fq.push_back(b);
      add_frame(b, d, pe, po, s2);
      len = d * (10 + int'(pe) + int'(s2));
      sync(len + 20);
      t = find_rinc(0);
      n_chk++; if (mism(t+1) != 0) begin n_fail++; $display("FAIL rand_line k=%0d got=%0d bad cycles exp=0", k, mism(t+1)); end
      n_chk++; if (cap_fd[t+len] !== 1'b1 || count_q(cap_fd) != 1) begin n_fail++; $display("FAIL rand_done k=%0d got=%b/%0d exp=1/1 len=%0d", k, cap_fd[t+len], count_q(cap_fd), len); end
      $display("frame rand data=%02h D=%0d par=%0d odd=%0d stop2=%0d len=%0d", b, d, pe, po, s2, len);
    end
  endtask

  initial begin
    logic [7:0] tmp;
    rrst_n      = 1'b0;
    enable      = 1'b0;
    fif.rempty  = 1'b1;
    fif.rdata   = 8'h00;
    pop_pend    = 1'b0;
    cfg(3, 0, 0, 0);

    fork
      forever begin
        @(negedge rclk);
        pop_pend = fif.rinc;
        cap_txd.push_back(txd);
        cap_rinc.push_back(fif.rinc);
        cap_fd.push_back(frame_done);
        cap_busy.push_back(busy);
      end
      forever begin
        @(posedge rclk);
        #1;
        if (pop_pend && fq.size() > 0) tmp = fq.pop_front();
        fif.rempty = (fq.size() == 0);
        fif.rdata  = (fq.size() > 0) ? fq[0] : 8'h00;
      end
    join_none

    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_empty();
    test_disable();
    test_cfg_change();
    test_reset_mid();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
